// File: rtl/dcache_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the direct-mapped write-back data cache.
package dcache_ctrl_pkg;

   localparam int ADDR_W         = 32;
   localparam int WORD_W         = 32;
   localparam int WORDS_PER_LINE = 8;
   localparam int LINE_W         = WORDS_PER_LINE * WORD_W;
   localparam int OFS_W          = 5;
   localparam int INDEX_W        = 5;
   localparam int NUM_LINES      = 1 << INDEX_W;
   localparam int TAG_W          = ADDR_W - INDEX_W - OFS_W;

   localparam int WSEL_LSB  = 2;
   localparam int WSEL_MSB  = 4;
   localparam int INDEX_LSB = OFS_W;
   localparam int INDEX_MSB = OFS_W + INDEX_W - 1;
   localparam int TAG_LSB   = OFS_W + INDEX_W;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WRITEBACK = 2'd1,
      ST_FETCH     = 2'd2,
      ST_REFILL    = 2'd3
   } state_t;

   function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                   input logic [INDEX_W-1:0] index);
      return {tag, index, {OFS_W{1'b0}}};
   endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: combinational read by index, synchronous line fill or word merge.
module dcache_sram
   import dcache_ctrl_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [INDEX_W-1:0] index,
   output logic               rd_valid,
   output logic               rd_dirty,
   output logic [TAG_W-1:0]   rd_tag,
   output logic [LINE_W-1:0]  rd_line,
   input  logic               line_we,
   input  logic [TAG_W-1:0]   line_tag,
   input  logic [LINE_W-1:0]  line_data,
   input  logic               word_we,
   input  logic [2:0]         word_sel,
   input  logic [WORD_W-1:0]  word_data
);

   logic [LINE_W-1:0]    data_q [NUM_LINES];
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [NUM_LINES-1:0] valid_q;
   logic [NUM_LINES-1:0] dirty_q;

   assign rd_valid = valid_q[index];
   assign rd_dirty = dirty_q[index];
   assign rd_tag   = tag_q[index];
   assign rd_line  = data_q[index];

   // Arrays carry no reset; only the valid/dirty bits define cache contents.
   always_ff @(posedge clk_i) begin
      if (line_we) begin
         data_q[index] <= line_data;
         tag_q[index]  <= line_tag;
      end else if (word_we) begin
         data_q[index][{word_sel, 5'b00000} +: WORD_W] <= word_data;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (line_we) begin
         valid_q[index] <= 1'b1;
         dirty_q[index] <= 1'b0;
      end else if (word_we) begin
         dirty_q[index] <= 1'b1;
      end
   end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller: hit logic, miss FSM, line memory port.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   IDLE      | serve hits combinationally; a miss picks WRITEBACK or FETCH
//   WRITEBACK | dirty victim line out to memory, held until mem_ack_i
//   FETCH     | request line for addr_i, capture mem_data_i on mem_ack_i
//   REFILL    | install captured line (valid, clean), then back to IDLE
module dcache_ctrl
   import dcache_ctrl_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_i,
   input  logic              write_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [WORD_W-1:0] wdata_i,
   output logic [WORD_W-1:0] rdata_o,
   output logic              stall_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   input  logic [LINE_W-1:0] mem_data_i,
   input  logic              mem_ack_i
);

   state_t state_q, state_d;

   logic [INDEX_W-1:0] index;
   logic [TAG_W-1:0]   tag;
   logic [2:0]         wsel;
   logic               unused_addr_bits;

   logic               rd_valid, rd_dirty;
   logic [TAG_W-1:0]   rd_tag;
   logic [LINE_W-1:0]  rd_line;
   logic [LINE_W-1:0]  fill_q;
   logic               hit, word_we, line_we, stall_raw;

   assign index            = addr_i[INDEX_MSB:INDEX_LSB];
   assign tag              = addr_i[ADDR_W-1:TAG_LSB];
   assign wsel             = addr_i[WSEL_MSB:WSEL_LSB];
   assign unused_addr_bits = ^addr_i[1:0];

   assign hit     = req_i & rd_valid & (rd_tag == tag);
   assign word_we = hit & write_i & (state_q == ST_IDLE);
   assign line_we = (state_q == ST_REFILL);
   assign rdata_o = hit ? rd_line[{wsel, 5'b00000} +: WORD_W] : '0;

   // Reset forces stall low even if the CPU is still presenting a request.
   assign stall_o = rst_i & stall_raw;

   dcache_sram u_sram (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .index     (index),
      .rd_valid  (rd_valid),
      .rd_dirty  (rd_dirty),
      .rd_tag    (rd_tag),
      .rd_line   (rd_line),
      .line_we   (line_we),
      .line_tag  (tag),
      .line_data (fill_q),
      .word_we   (word_we),
      .word_sel  (wsel),
      .word_data (wdata_i)
   );

   always_ff @(posedge clk_i) begin
      if (state_q == ST_FETCH && mem_ack_i) begin
         fill_q <= mem_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      stall_raw    = 1'b0;
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      mem_addr_o   = '0;
      mem_data_o   = '0;
      case (state_q)
         ST_IDLE: begin
            if (req_i && !hit) begin
               stall_raw = 1'b1;
               state_d   = (rd_valid && rd_dirty) ? ST_WRITEBACK : ST_FETCH;
            end
         end
         ST_WRITEBACK: begin
            stall_raw    = 1'b1;
            mem_enable_o = 1'b1;
            mem_write_o  = 1'b1;
            mem_addr_o   = line_addr(rd_tag, index);
            mem_data_o   = rd_line;
            if (mem_ack_i) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            stall_raw    = 1'b1;
            mem_enable_o = 1'b1;
            mem_addr_o   = line_addr(tag, index);
            if (mem_ack_i) state_d = ST_REFILL;
         end
         ST_REFILL: begin
            stall_raw = 1'b1;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: behavioural line memory with fixed latency, vector table plus miss sequences.
module tb_dcache_ctrl;

   localparam int LAT = 10;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b0;
   logic         req_i = 1'b0;
   logic         write_i = 1'b0;
   logic [31:0]  addr_i = '0;
   logic [31:0]  wdata_i = '0;
   logic [31:0]  rdata_o;
   logic         stall_o;
   logic         mem_enable_o;
   logic         mem_write_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o;
   logic [255:0] mem_data_i = '0;
   logic         mem_ack_i;
   logic         resp_ack = 1'b0;
   logic         inj_ack = 1'b0;

   assign mem_ack_i = resp_ack | inj_ack;

   dcache_ctrl dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .req_i        (req_i),
      .write_i      (write_i),
      .addr_i       (addr_i),
      .wdata_i      (wdata_i),
      .rdata_o      (rdata_o),
      .stall_o      (stall_o),
      .mem_enable_o (mem_enable_o),
      .mem_write_o  (mem_write_o),
      .mem_addr_o   (mem_addr_o),
      .mem_data_o   (mem_data_o),
      .mem_data_i   (mem_data_i),
      .mem_ack_i    (mem_ack_i)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Backing memory: explicit lines, otherwise each word holds A000_0000 + its own byte address.
   logic [255:0] mem_store [logic [31:0]];
   logic [32:0]  log_q [$];
   logic [255:0] last_wb;

   function automatic logic [255:0] pat_line(input logic [31:0] a);
      logic [255:0] l;
      for (int k = 0; k < 8; k++) l[k*32 +: 32] = 32'hA000_0000 + a + 32'(k * 4);
      return l;
   endfunction

   function automatic logic [255:0] line_of(input logic [31:0] a);
      if (mem_store.exists(a)) return mem_store[a];
      return pat_line(a);
   endfunction

   initial begin : responder
      int busy;
      busy = 0;
      forever begin
         @(negedge clk_i);
         resp_ack = 1'b0;
         if (!rst_i || !mem_enable_o) begin
            busy = 0;
         end else begin
            busy++;
            if (busy == LAT) begin
               busy = 0;
               resp_ack = 1'b1;
               if (mem_write_o) begin
                  mem_store[mem_addr_o] = mem_data_o;
                  last_wb = mem_data_o;
                  log_q.push_back({1'b1, mem_addr_o});
               end else begin
                  mem_data_i = line_of(mem_addr_o);
                  log_q.push_back({1'b0, mem_addr_o});
               end
            end
         end
      end
   end

   task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         output int stalls, output logic [31:0] rd);
      bit done;
      done = 1'b0;
      @(posedge clk_i); #1;
      req_i = 1'b1; write_i = wr; addr_i = a; wdata_i = d;
      stalls = 0;
      rd = '0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_i);
         if (!stall_o) begin
            rd = rdata_o;
            done = 1'b1;
            break;
         end
         stalls++;
      end
      if (!done) begin
         n_cmp++;
         n_err++;
         $display("FAIL access_timeout: addr %0h still stalled after 200 cycles, expected completion", a);
      end
      @(posedge clk_i); #1;
      req_i = 1'b0; write_i = 1'b0;
   endtask

   typedef struct {
      logic        req;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_stall;
   } vec_t;

   vec_t vecs [11];

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int           st;
      int           n0;
      logic [31:0]  rd;
      logic [255:0] l40, l80;

      for (int k = 0; k < 8; k++) l40[k*32 +: 32] = 32'h1111_1111 * (k + 1);
      mem_store[32'h40] = l40;

      vecs[0]  = '{1'b0, 1'b0, 32'h40,  32'h0,         32'h0,         1'b0};
      vecs[1]  = '{1'b1, 1'b0, 32'h40,  32'h0,         32'h1111_1111, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 32'h48,  32'h0,         32'h3333_3333, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 32'h5C,  32'h0,         32'h8888_8888, 1'b0};
      vecs[4]  = '{1'b1, 1'b1, 32'h48,  32'hCAFE_F00D, 32'h3333_3333, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 32'h48,  32'h0,         32'hCAFE_F00D, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 32'h44,  32'h0,         32'hDEAD_BEEF, 1'b0};
      vecs[7]  = '{1'b1, 1'b1, 32'h5C,  32'h1234_5678, 32'h8888_8888, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 32'h5C,  32'h0,         32'h1234_5678, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 32'h4C,  32'h0,         32'h4444_4444, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 32'h440, 32'h0,         32'h0,         1'b0};

      // Reset with a request already presented.
      req_i = 1'b1; addr_i = 32'h40;
      #3;
      check("rst_stall", stall_o, 0);
      check("rst_mem_enable", mem_enable_o, 0);
      check("rst_mem_write", mem_write_o, 0);
      check("rst_mem_addr", mem_addr_o, 0);
      check("rst_mem_data", mem_data_o, 0);
      check("rst_rdata", rdata_o, 0);
      req_i = 1'b0;
      #19 rst_i = 1'b1;

      // Clean load miss then hit.
      access(1'b0, 32'h40, 32'h0, st, rd);
      check("miss40_stalls", st, 12);
      check("miss40_rdata", rd, 32'h1111_1111);
      check("miss40_ops", log_q.size(), 1);
      check("miss40_op", log_q[0], {1'b0, 32'h40});
      access(1'b0, 32'h40, 32'h0, st, rd);
      check("hit40_stalls", st, 0);
      check("hit40_rdata", rd, 32'h1111_1111);

      // Store hit.
      access(1'b1, 32'h44, 32'hDEAD_BEEF, st, rd);
      check("st44_stalls", st, 0);
      access(1'b0, 32'h44, 32'h0, st, rd);
      check("ld44_rdata", rd, 32'hDEAD_BEEF);
      check("st44_no_mem", log_q.size(), 1);

      // Single-cycle hit vectors.
      for (int i = 0; i < 11; i++) begin
         @(posedge clk_i); #1;
         req_i = vecs[i].req; write_i = vecs[i].wr; addr_i = vecs[i].addr; wdata_i = vecs[i].wdata;
         @(negedge clk_i);
         check($sformatf("vec%0d_stall", i), stall_o, vecs[i].exp_stall);
         check($sformatf("vec%0d_rdata", i), rdata_o, vecs[i].exp_rdata);
         check($sformatf("vec%0d_mem_enable", i), mem_enable_o, 0);
      end
      @(posedge clk_i); #1;
      req_i = 1'b0; write_i = 1'b0;

      // Dirty eviction of index 2.
      l40[1*32 +: 32] = 32'hDEAD_BEEF;
      l40[2*32 +: 32] = 32'hCAFE_F00D;
      l40[7*32 +: 32] = 32'h1234_5678;
      n0 = log_q.size();
      access(1'b0, 32'h440, 32'h0, st, rd);
      check("miss440_stalls", st, 22);
      check("miss440_rdata", rd, 32'hA000_0440);
      check("miss440_ops", log_q.size() - n0, 2);
      check("miss440_wb_op", log_q[n0], {1'b1, 32'h40});
      check("miss440_fetch_op", log_q[n0+1], {1'b0, 32'h440});
      check("miss440_wb_data", last_wb, l40);

      // Store miss to an unused line, then its eviction.
      n0 = log_q.size();
      access(1'b1, 32'h80, 32'h5555_AAAA, st, rd);
      check("stmiss80_stalls", st, 12);
      check("stmiss80_ops", log_q.size() - n0, 1);
      check("stmiss80_op", log_q[n0], {1'b0, 32'h80});
      access(1'b0, 32'h80, 32'h0, st, rd);
      check("ld80_stalls", st, 0);
      check("ld80_rdata", rd, 32'h5555_AAAA);
      access(1'b0, 32'h84, 32'h0, st, rd);
      check("ld84_rdata", rd, 32'hA000_0084);
      l80 = pat_line(32'h80);
      l80[31:0] = 32'h5555_AAAA;
      n0 = log_q.size();
      access(1'b0, 32'h480, 32'h0, st, rd);
      check("miss480_stalls", st, 22);
      check("miss480_wb_op", log_q[n0], {1'b1, 32'h80});
      check("miss480_wb_data", last_wb, l80);
      check("miss480_rdata", rd, 32'hA000_0480);

      // Reset in the middle of a fetch.
      n0 = log_q.size();
      @(posedge clk_i); #1;
      req_i = 1'b1; write_i = 1'b0; addr_i = 32'h40;
      repeat (5) @(negedge clk_i);
      check("prerst_fetch_enable", mem_enable_o, 1);
      check("prerst_fetch_addr", mem_addr_o, 32'h40);
      #2 rst_i = 1'b0;
      #1;
      check("midrst_enable", mem_enable_o, 0);
      check("midrst_stall", stall_o, 0);
      check("midrst_addr", mem_addr_o, 0);
      req_i = 1'b0;
      @(negedge clk_i);
      #2 rst_i = 1'b1;
      check("midrst_no_ack_logged", log_q.size() - n0, 0);
      access(1'b0, 32'h40, 32'h0, st, rd);
      check("postrst_stalls", st, 12);
      check("postrst_rdata", rd, 32'h1111_1111);

      // Stray ack while idle.
      @(posedge clk_i); #1;
      inj_ack = 1'b1;
      @(negedge clk_i);
      check("idleack_stall", stall_o, 0);
      check("idleack_enable", mem_enable_o, 0);
      @(posedge clk_i); #1;
      inj_ack = 1'b0;
      @(negedge clk_i);
      check("idleack_enable2", mem_enable_o, 0);
      check("idleack_addr", mem_addr_o, 0);
      access(1'b0, 32'h40, 32'h0, st, rd);
      check("idleack_hit_stalls", st, 0);
      check("idleack_hit_rdata", rd, 32'h1111_1111);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
